// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types and widths for the architectural register debug reader.
// XLEN and PREG_W fix the PRF data and physical index widths; AREG_W is the
// architectural index width of the debug port.
package dbg_pkg;

    localparam int XLEN   = 32;
    localparam int PREG_W = 7;
    localparam int AREG_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        HALT_WAIT,
        LOOKUP,
        READ,
        RESP
    } dbg_state_e;

    // One response beat as presented on the rsp_* outputs.
    typedef struct packed {
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [XLEN-1:0]   data;
        logic              last;
        logic              err;
    } dbg_rsp_t;

endpackage

// File: rtl/arch_reg_debug_reader_if.sv
// arch_reg_debug_reader_if: request/response handshake, rename-map read port,
// PRF read port and halt signals of the debug reader.
// slave  = the debug reader itself.
// master = the surrounding core / bench (requester, rename map, PRF, ROB).
interface arch_reg_debug_reader_if;
    import dbg_pkg::*;

    // Request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_all;
    logic [AREG_W-1:0] req_areg;

    // Rename-map read port (combinational, same cycle)
    logic [AREG_W-1:0] map_rd_idx;
    logic [PREG_W-1:0] map_rd_preg;

    // PRF read port (combinational, same cycle)
    logic [PREG_W-1:0] prf_rd_addr;
    logic [XLEN-1:0]   prf_rd_data;

    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [AREG_W-1:0] rsp_areg;
    logic [PREG_W-1:0] rsp_preg;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    // Pipeline halt
    logic              halt_req;
    logic              rob_empty;

    modport slave (
        input  req_valid, req_all, req_areg, map_rd_preg, prf_rd_data,
               rsp_ready, rob_empty,
        output req_ready, map_rd_idx, prf_rd_addr, rsp_valid, rsp_areg,
               rsp_preg, rsp_data, rsp_last, rsp_err, halt_req
    );

    modport master (
        output req_valid, req_all, req_areg, map_rd_preg, prf_rd_data,
               rsp_ready, rob_empty,
        input  req_ready, map_rd_idx, prf_rd_addr, rsp_valid, rsp_areg,
               rsp_preg, rsp_data, rsp_last, rsp_err, halt_req
    );

endinterface

// File: rtl/arch_reg_debug_reader.sv
// arch_reg_debug_reader: returns committed architectural register values.
// Each beat looks up arch reg -> phys reg in the rename map, then reads that
// phys reg from the PRF. A request returns one register or dumps all of them.
// Optional macro DBG_HALT_EN: stall dispatch and wait for an empty ROB before
// the first beat, with a timeout that ends the request with rsp_err=1.
module arch_reg_debug_reader
    import dbg_pkg::*;
#(
    parameter int NUM_AREGS    = 32,
    parameter int HALT_TIMEOUT = 256
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    arch_reg_debug_reader_if.slave  dbg
);

    localparam logic [AREG_W-1:0] LAST_AREG = AREG_W'(NUM_AREGS - 1);

    dbg_state_e        r_state;
    logic              r_all;        // request is a full dump
    logic [AREG_W-1:0] r_cur_areg;   // beat counter / current arch index
    logic [AREG_W-1:0] r_map_rd_idx;
    logic [PREG_W-1:0] r_preg_q;     // looked-up phys index, drives the PRF
    dbg_rsp_t          r_rsp;
    logic              r_rsp_valid;
    logic              r_req_ready;

`ifdef DBG_HALT_EN
    localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
    logic              r_halt_req;
    logic [CNT_W-1:0]  r_halt_cnt;
`endif

    logic w_req_fire;
    logic w_in_range;
    logic w_is_last;
    logic w_zero_data;
    logic w_unused;

    assign w_req_fire  = dbg.req_valid && r_req_ready;
    assign w_is_last   = !r_all || (r_cur_areg == LAST_AREG);
    // x0 reads as zero whatever the PRF holds; out-of-range indices read as zero too
    assign w_zero_data = (r_cur_areg == '0) || !w_in_range;

    // Range check only exists when the index width can exceed NUM_AREGS
    generate
        if (NUM_AREGS < (1 << AREG_W)) begin : g_range_chk
            assign w_in_range = (r_cur_areg < AREG_W'(NUM_AREGS));
        end else begin : g_range_full
            assign w_in_range = 1'b1;
        end
    endgenerate

`ifdef DBG_HALT_EN
    assign w_unused = 1'b0;
`else
    assign w_unused = dbg.rob_empty ^ HALT_TIMEOUT[0];
`endif

    // Request FSM: sequences LOOKUP -> READ -> RESP per beat, all outputs registered
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_all        <= 1'b0;
            r_cur_areg   <= '0;
            r_map_rd_idx <= '0;
            r_preg_q     <= '0;
            r_rsp        <= '0;
            r_rsp_valid  <= 1'b0;
            r_req_ready  <= 1'b1;
`ifdef DBG_HALT_EN
            r_halt_req   <= 1'b0;
            r_halt_cnt   <= '0;
`endif
        end else begin
            // NOTE: every register here uses <= so all state updates land together at the edge.
            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_all        <= dbg.req_all;
                        r_cur_areg   <= dbg.req_all ? '0 : dbg.req_areg;
                        r_map_rd_idx <= dbg.req_all ? '0 : dbg.req_areg;
                        r_req_ready  <= 1'b0;
`ifdef DBG_HALT_EN
                        r_halt_req   <= 1'b1;
                        r_halt_cnt   <= '0;
                        r_state      <= HALT_WAIT;
`else
                        r_state      <= LOOKUP;
`endif
                    end
                end

`ifdef DBG_HALT_EN
                HALT_WAIT: begin
                    if (dbg.rob_empty) begin
                        r_state <= LOOKUP;
                    end else if (r_halt_cnt == CNT_W'(HALT_TIMEOUT - 1)) begin
                        // ROB never drained: terminate the whole request with an error beat
                        r_rsp.areg  <= r_cur_areg;
                        r_rsp.preg  <= '0;
                        r_rsp.data  <= '0;
                        r_rsp.last  <= 1'b1;
                        r_rsp.err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_halt_cnt <= r_halt_cnt + 1'b1;
                    end
                end
`endif

                LOOKUP: begin
                    r_preg_q <= dbg.map_rd_preg;
                    r_state  <= READ;
                end

                READ: begin
                    r_rsp.areg  <= r_cur_areg;
                    r_rsp.preg  <= r_preg_q;
                    r_rsp.data  <= w_zero_data ? '0 : dbg.prf_rd_data;
                    r_rsp.last  <= w_is_last;
                    r_rsp.err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end

                RESP: begin
                    if (dbg.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp.last) begin
                            r_req_ready <= 1'b1;
`ifdef DBG_HALT_EN
                            r_halt_req  <= 1'b0;
`endif
                            r_state     <= IDLE;
                        end else begin
                            r_cur_areg   <= r_cur_areg + 1'b1;
                            r_map_rd_idx <= r_cur_areg + 1'b1;
                            r_state      <= LOOKUP;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign dbg.req_ready   = r_req_ready;
    assign dbg.map_rd_idx  = r_map_rd_idx;
    assign dbg.prf_rd_addr = r_preg_q;
    assign dbg.rsp_valid   = r_rsp_valid;
    assign dbg.rsp_areg    = r_rsp.areg;
    assign dbg.rsp_preg    = r_rsp.preg;
    assign dbg.rsp_data    = r_rsp.data;
    assign dbg.rsp_last    = r_rsp.last;
    assign dbg.rsp_err     = r_rsp.err;
`ifdef DBG_HALT_EN
    assign dbg.halt_req    = r_halt_req;
`else
    assign dbg.halt_req    = 1'b0;
`endif

endmodule

// File: tb/tb_arch_reg_debug_reader.sv
// tb_arch_reg_debug_reader: directed bench for arch_reg_debug_reader.
// Rename map and PRF are modelled as bench arrays read combinationally.
// Halt sequences are included when DBG_HALT_EN is defined.
module tb_arch_reg_debug_reader;
    import dbg_pkg::*;

`ifdef DBG_HALT_EN
    localparam bit HALT_ON  = 1'b1;
    localparam int BASE_LAT = 4;   // one HALT_WAIT cycle with rob_empty=1
`else
    localparam bit HALT_ON  = 1'b0;
    localparam int BASE_LAT = 3;   // LOOKUP, READ, then RESP
`endif

    logic clk;
    logic rst_n;

    logic [PREG_W-1:0] map_mem [32];
    logic [XLEN-1:0]   prf_mem [128];

    int n_checks = 0;
    int n_pass   = 0;

    arch_reg_debug_reader_if bus();

    arch_reg_debug_reader #(
        .NUM_AREGS    (32),
        .HALT_TIMEOUT (256)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .dbg     (bus)
    );

    assign bus.map_rd_preg = map_mem[bus.map_rd_idx];
    assign bus.prf_rd_data = prf_mem[bus.prf_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [XLEN-1:0]   data;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [PREG_W-1:0] exp_preg(input int a);
        return map_mem[a];
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int a);
        return (a == 0) ? '0 : prf_mem[map_mem[a]];
    endfunction

    task automatic send_req(input logic all, input logic [AREG_W-1:0] areg);
        @(negedge clk);
        check("req_ready_before_req", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_all   = all;
        bus.req_areg  = areg;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Counts falling edges until rsp_valid is seen, bounded by max_cyc
    task automatic wait_rsp(input int max_cyc, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.rsp_valid && gap < max_cyc);
        if (!bus.rsp_valid) check("rsp_valid_timeout", bus.rsp_valid, 1'b1);
    endtask

    function automatic logic [63:0] snap();
        dbg_rsp_t s;
        s.areg = bus.rsp_areg;
        s.preg = bus.rsp_preg;
        s.data = bus.rsp_data;
        s.last = bus.rsp_last;
        s.err  = bus.rsp_err;
        return 64'(s);
    endfunction

    task automatic run_dump(input int stall_beat, input int reset_beat);
        int gap;
        logic [63:0] held;
        send_req(1'b1, 5'd7);
        for (int b = 0; b < 32; b++) begin
            wait_rsp(20, gap);
            if (!bus.rsp_valid) return;
            check("dump_gap",       gap, (b == 0) ? BASE_LAT : 3);
            check("dump_areg",      bus.rsp_areg, b);
            check("dump_preg",      bus.rsp_preg, exp_preg(b));
            check("dump_data",      bus.rsp_data, exp_data(b));
            check("dump_last",      bus.rsp_last, (b == 31));
            check("dump_req_ready", bus.req_ready, 1'b0);
            check("dump_halt_req",  bus.halt_req, HALT_ON);
            if (b == reset_beat) begin
                rst_n = 1'b0;
                #2;
                check("rst_async_rsp_valid", bus.rsp_valid, 1'b0);
                check("rst_async_req_ready", bus.req_ready, 1'b1);
                check("rst_async_map_idx",   bus.map_rd_idx, 0);
                check("rst_async_halt_req",  bus.halt_req, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("rst_release_req_ready", bus.req_ready, 1'b1);
                check("rst_release_rsp_valid", bus.rsp_valid, 1'b0);
                return;
            end
            if (b == stall_beat) begin
                bus.rsp_ready = 1'b0;
                held = snap();
                repeat (5) begin
                    @(negedge clk);
                    check("stall_rsp_valid", bus.rsp_valid, 1'b1);
                    check("stall_rsp_hold",  snap(), held);
                end
                bus.rsp_ready = 1'b1;
            end
        end
        @(negedge clk);
        check("dump_end_rsp_valid", bus.rsp_valid, 1'b0);
        check("dump_end_req_ready", bus.req_ready, 1'b1);
        check("dump_end_halt_req",  bus.halt_req, 1'b0);
    endtask

    task automatic single_read(input vec_t v, input string tag);
        int gap;
        send_req(1'b0, v.areg);
        wait_rsp(20, gap);
        check({tag, "_latency"},   gap, BASE_LAT);
        check({tag, "_areg"},      bus.rsp_areg, v.areg);
        check({tag, "_preg"},      bus.rsp_preg, v.preg);
        check({tag, "_data"},      bus.rsp_data, v.data);
        check({tag, "_last"},      bus.rsp_last, 1'b1);
        check({tag, "_err"},       bus.rsp_err, 1'b0);
        check({tag, "_req_ready"}, bus.req_ready, 1'b0);
        check({tag, "_halt_req"},  bus.halt_req, HALT_ON);
        @(negedge clk);
        check({tag, "_done_valid"}, bus.rsp_valid, 1'b0);
        check({tag, "_done_ready"}, bus.req_ready, 1'b1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_all   = 1'b0;
        bus.req_areg  = '0;
        bus.rsp_ready = 1'b1;
        bus.rob_empty = HALT_ON;
        rst_n         = 1'b0;

        // map[a] = a + 64, PRF[p] = C0DE_0000 + p, with the directed overrides
        for (int a = 0; a < 32; a++) map_mem[a] = 7'(a + 64);
        for (int p = 0; p < 128; p++) prf_mem[p] = 32'hC0DE_0000 + 32'(p);
        map_mem[10] = 7'd40;
        prf_mem[40] = 32'hDEAD_BEEF;
        map_mem[0]  = 7'd5;
        prf_mem[5]  = 32'h0000_1234;

        vecs[0] = '{5'd10, 7'd40, 32'hDEAD_BEEF};
        vecs[1] = '{5'd0,  7'd5,  32'h0000_0000};
        vecs[2] = '{5'd31, 7'd95, 32'hC0DE_005F};
        vecs[3] = '{5'd1,  7'd65, 32'hC0DE_0041};
        vecs[4] = '{5'd17, 7'd81, 32'hC0DE_0051};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_req_ready",   bus.req_ready, 1'b1);
        check("reset_rsp_valid",   bus.rsp_valid, 1'b0);
        check("reset_rsp_data",    bus.rsp_data, 0);
        check("reset_rsp_last",    bus.rsp_last, 1'b0);
        check("reset_map_rd_idx",  bus.map_rd_idx, 0);
        check("reset_prf_rd_addr", bus.prf_rd_addr, 0);
        check("reset_halt_req",    bus.halt_req, 1'b0);
        rst_n = 1'b1;

        // Single reads from the vector table
        for (int i = 0; i < 5; i++) single_read(vecs[i], $sformatf("vec%0d", i));

        // Full dump, no backpressure
        run_dump(-1, -1);
        // Full dump, beat 4 held for 5 cycles
        run_dump(4, -1);
        // Full dump, reset at beat 12, then a clean single read
        run_dump(-1, 12);
        single_read(vecs[0], "post_reset");

`ifdef DBG_HALT_EN
        begin
            int k;
            int gap;
            // ROB busy for 10 cycles after accept, then drains
            bus.rob_empty = 1'b0;
            send_req(1'b0, 5'd10);
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (!bus.rsp_valid) check("halt_wait_halt_req", bus.halt_req, 1'b1);
                bus.rob_empty = (k >= 11);
            end while (!bus.rsp_valid && k < 40);
            check("halt_latency",  k, 14);
            check("halt_data",     bus.rsp_data, 32'hDEAD_BEEF);
            check("halt_err",      bus.rsp_err, 1'b0);
            check("halt_rsp_halt", bus.halt_req, 1'b1);
            @(negedge clk);
            check("halt_drop", bus.halt_req, 1'b0);

            // ROB never drains: timeout beat
            bus.rob_empty = 1'b0;
            send_req(1'b0, 5'd3);
            wait_rsp(300, gap);
            check("timeout_latency",  gap, 257);
            check("timeout_err",      bus.rsp_err, 1'b1);
            check("timeout_last",     bus.rsp_last, 1'b1);
            check("timeout_data",     bus.rsp_data, 0);
            check("timeout_halt_req", bus.halt_req, 1'b1);
            @(negedge clk);
            check("timeout_halt_drop", bus.halt_req, 1'b0);
            check("timeout_req_ready", bus.req_ready, 1'b1);
            bus.rob_empty = 1'b1;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
